icache_assoc: RTL and testbench

ICACHE_ASSOC -- requirements
Module: icache_assoc

---
 rtl/icache_pkg.sv | 32 +++
 rtl/icache_if.sv | 30 +++
 rtl/icache_way.sv | 48 ++++
 rtl/icache_assoc.sv | 179 +++++++++++++++++
 tb/tb_icache_assoc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Contents: controller state enum and the address-field width helpers
// (byte offset, word select, index, pointer widths).
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_MISS   = 2'd2
    } state_e;

    // log2 that never returns 0, for vectors that must be at least 1 bit wide
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Byte-offset bits within one refill line
    function automatic int unsigned off_bits(input int unsigned line_w);
        return $clog2(line_w / 8);
    endfunction

    // Word-select bits (upper part of the line offset)
    function automatic int unsigned wsel_bits(input int unsigned line_w, input int unsigned data_w);
        return clog2_min1(line_w / data_w);
    endfunction

    // Set-index bits
    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Cache bus bundle: CPU-side request/response plus memory refill signals.
// master: requester/memory side (drives addr, read_en, flush, mem_data_in, mem_ready)
// slave : the cache (drives data_out, data_valid, hit, busy, mem_addr, mem_req)
interface icache_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 128
);
    logic [ADDR_W-1:0] addr;
    logic              read_en;
    logic              flush;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              hit;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic [LINE_W-1:0] mem_data_in;
    logic              mem_ready;

    modport master (
        output addr, read_en, flush, mem_data_in, mem_ready,
        input  data_out, data_valid, hit, busy, mem_addr, mem_req
    );

    modport slave (
        input  addr, read_en, flush, mem_data_in, mem_ready,
        output data_out, data_valid, hit, busy, mem_addr, mem_req
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and line storage with tag compare.
// Ports: clk, rst (sync, active-high), clear_i (invalidate all), we_i (fill),
//        idx_i/tag_i (set and tag for both lookup and fill), line_i (fill data),
//        match_c_o / valid_c_o / line_c_o (combinational view of the indexed set).
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned TAG_W  = 24,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned SETS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] line_i,
    output logic              match_c_o,
    output logic              valid_c_o,
    output logic [LINE_W-1:0] line_c_o
);
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    // Valid bits: cleared by reset or flush, set on fill
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tag and line storage are not reset; valid bits gate their use
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[idx_i]  <= tag_i;
            line_q[idx_i] <= line_i;
        end
    end

    assign valid_c_o = valid_q[idx_i];
    assign match_c_o = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign line_c_o  = line_q[idx_i];
endmodule

// File: rtl/icache_assoc.sv
// Set-associative read-only instruction cache with round-robin replacement.
// Ports: clk, rst (sync, active-high), bus (icache_if.slave): addr/read_en/flush
//        requests, data_out/data_valid/hit results, busy, and the mem_req/mem_addr/
//        mem_data_in/mem_ready line-refill handshake.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned SETS   = 16,
    parameter int unsigned WAYS   = 2
) (
    input  logic     clk,
    input  logic     rst,
    icache_if.slave  bus
);
    localparam int unsigned OFF_W  = off_bits(LINE_W);
    localparam int unsigned IDX_W  = idx_bits(SETS);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WORDS  = LINE_W / DATA_W;
    localparam int unsigned WSEL_W = wsel_bits(LINE_W, DATA_W);
    localparam int unsigned BYTE_W = $clog2(DATA_W / 8);
    localparam int unsigned PTR_W  = clog2_min1(WAYS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_valid_q, data_valid_d;
    logic                hit_q, hit_d;
    logic                busy_q, busy_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PTR_W-1:0]    ptr_q [SETS];

    logic [IDX_W-1:0]    idx_c;
    logic [TAG_W-1:0]    tag_c;
    logic [WSEL_W-1:0]   wsel_c;
    logic                flush_c, fill_c, any_hit_c;
    logic [PTR_W-1:0]    victim_c;
    logic [LINE_W-1:0]   hit_line_c;
    logic                match_c [WAYS];
    logic                valid_c [WAYS];
    logic                we_c    [WAYS];
    logic [LINE_W-1:0]   line_c  [WAYS];

    // Field split of the latched request address; mask keeps wsel 0 when a line is one word
    assign idx_c  = addr_q[OFF_W +: IDX_W];
    assign tag_c  = addr_q[ADDR_W-1 -: TAG_W];
    assign wsel_c = WSEL_W'(addr_q >> BYTE_W) & WSEL_W'(WORDS - 1);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        // Reset wins over a simultaneous refill
        assign we_c[w] = fill_c && !rst && (victim_c == PTR_W'(w));

        icache_way #(
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W),
            .LINE_W (LINE_W),
            .SETS   (SETS)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .clear_i   (flush_c),
            .we_i      (we_c[w]),
            .idx_i     (idx_c),
            .tag_i     (tag_c),
            .line_i    (bus.mem_data_in),
            .match_c_o (match_c[w]),
            .valid_c_o (valid_c[w]),
            .line_c_o  (line_c[w])
        );
    end

    // Hit detection and line select across ways
    always_comb begin
        any_hit_c  = 1'b0;
        hit_line_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (match_c[w]) begin
                any_hit_c  = 1'b1;
                hit_line_c = line_c[w];
            end
        end
    end

    // Victim: lowest-index invalid way, else the set's round-robin pointer
    always_comb begin
        victim_c = ptr_q[idx_c];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_c[w]) victim_c = PTR_W'(w);
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        hit_d        = 1'b0;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        flush_c      = 1'b0;
        fill_c       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    flush_c = 1'b1;
                end else if (bus.read_en) begin
                    addr_d  = bus.addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (any_hit_c) begin
                    state_d      = S_IDLE;
                    data_out_d   = hit_line_c[int'(wsel_c) * DATA_W +: DATA_W];
                    data_valid_d = 1'b1;
                    hit_d        = 1'b1;
                end else begin
                    state_d    = S_MISS;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag_c, idx_c, {OFF_W{1'b0}}};
                end
            end
            S_MISS: begin
                if (bus.mem_ready) begin
                    fill_c       = 1'b1;
                    state_d      = S_IDLE;
                    mem_req_d    = 1'b0;
                    data_valid_d = 1'b1;
                    data_out_d   = bus.mem_data_in[int'(wsel_c) * DATA_W +: DATA_W];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            hit_q        <= hit_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Round-robin pointers: cleared by reset/flush, advance on each fill of their set
    always_ff @(posedge clk) begin
        if (rst || flush_c) begin
            for (int s = 0; s < int'(SETS); s++) ptr_q[s] <= '0;
        end else if (fill_c) begin
            ptr_q[idx_c] <= (ptr_q[idx_c] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[idx_c] + PTR_W'(1);
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.hit        = hit_q;
    assign bus.busy       = busy_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench: a 2-way and a direct-mapped cache share one stimulus;
// a per-set way-list model predicts hit/miss, refill address and returned data.
module tb_icache_assoc;
    localparam int unsigned NS = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr = '0;
    logic         read_en = 1'b0;
    logic         flush = 1'b0;
    logic         mem_ready = 1'b0;
    logic [127:0] mem_data_in = '0;
    int           sel = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    icache_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) if2w ();
    icache_if #(.ADDR_W(32), .DATA_W(32), .LINE_W(128)) if1w ();

    assign if2w.addr = addr;        assign if1w.addr = addr;
    assign if2w.read_en = read_en;  assign if1w.read_en = read_en;
    assign if2w.flush = flush;      assign if1w.flush = flush;
    assign if2w.mem_ready = mem_ready;     assign if1w.mem_ready = mem_ready;
    assign if2w.mem_data_in = mem_data_in; assign if1w.mem_data_in = mem_data_in;

    icache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_W(128), .SETS(NS), .WAYS(2))
        dut2w (.clk(clk), .rst(rst), .bus(if2w));
    icache_assoc #(.ADDR_W(32), .DATA_W(32), .LINE_W(128), .SETS(NS), .WAYS(1))
        dut1w (.clk(clk), .rst(rst), .bus(if1w));

    // Observed outputs of the cache under test
    logic [31:0] o_data, o_maddr;
    logic        o_dv, o_hit, o_busy, o_mreq;
    always_comb begin
        o_data = if2w.data_out; o_dv = if2w.data_valid; o_hit = if2w.hit;
        o_busy = if2w.busy; o_mreq = if2w.mem_req; o_maddr = if2w.mem_addr;
        if (sel == 1) begin
            o_data = if1w.data_out; o_dv = if1w.data_valid; o_hit = if1w.hit;
            o_busy = if1w.busy; o_mreq = if1w.mem_req; o_maddr = if1w.mem_addr;
        end
    end

    // Reference model: per set, a list of way entries and a replacement pointer
    int           m_ways = 2;
    bit           m_valid [NS][2];
    logic [31:0]  m_tag   [NS][2];
    logic [127:0] m_line  [NS][2];
    int           m_ptr   [NS];

    task automatic model_clear();
        for (int s = 0; s < int'(NS); s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_fill(input int s, input logic [31:0] tag, input logic [127:0] line);
        int v = -1;
        for (int w = 0; w < m_ways; w++) if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) v = m_ptr[s];
        m_valid[s][v] = 1'b1; m_tag[s][v] = tag; m_line[s][v] = line;
        m_ptr[s] = (m_ptr[s] + 1) % m_ways;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One read transaction with optional MISS stall and ignored read_en/flush pokes
    task automatic do_read(input logic [31:0] a, input logic [127:0] line, input int stall, input bit poke);
        int s = int'((a >> 4) & 32'hF);
        int wd = int'((a >> 2) & 32'h3);
        logic [31:0] tag = a >> 8;
        bit exp_hit = 1'b0;
        logic [31:0] exp_data = line[32*wd +: 32];
        for (int w = 0; w < m_ways; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag) begin
                exp_hit = 1'b1; exp_data = m_line[s][w][32*wd +: 32];
            end
        @(negedge clk); addr = a; read_en = 1'b1;
        @(negedge clk); read_en = 1'b0;
        n_tests++;
        if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_lookup a=%h got %b want 1", a, o_busy); end
        @(negedge clk);
        if (exp_hit) begin
            n_tests++;
            if ({o_dv, o_hit, o_mreq, o_busy, o_data} !== {4'b1100, exp_data}) begin
                n_fail++;
                $display("FAIL hit_result a=%h got dv=%b hit=%b req=%b busy=%b data=%h want 1 1 0 0 %h",
                         a, o_dv, o_hit, o_mreq, o_busy, o_data, exp_data);
            end
        end else begin
            n_tests++;
            if ({o_dv, o_mreq, o_busy, o_maddr} !== {3'b011, a & 32'hFFFF_FFF0}) begin
                n_fail++;
                $display("FAIL miss_req a=%h got dv=%b req=%b busy=%b maddr=%h want 0 1 1 %h",
                         a, o_dv, o_mreq, o_busy, o_maddr, a & 32'hFFFF_FFF0);
            end
            for (int i = 0; i < stall; i++) begin
                if (poke) begin read_en = i[0]; flush = i[1]; end
                @(negedge clk);
                n_tests++;
                if ({o_dv, o_mreq, o_maddr} !== {2'b01, a & 32'hFFFF_FFF0}) begin
                    n_fail++;
                    $display("FAIL stall_hold a=%h cyc=%0d got dv=%b req=%b maddr=%h", a, i, o_dv, o_mreq, o_maddr);
                end
            end
            read_en = 1'b0; flush = 1'b0;
            mem_data_in = line; mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            n_tests++;
            if ({o_dv, o_hit, o_mreq, o_busy, o_data} !== {4'b1000, exp_data}) begin
                n_fail++;
                $display("FAIL fill_result a=%h got dv=%b hit=%b req=%b busy=%b data=%h want 1 0 0 0 %h",
                         a, o_dv, o_hit, o_mreq, o_busy, o_data, exp_data);
            end
            model_fill(s, tag, line);
        end
        @(negedge clk);
        n_tests++;
        if ({o_dv, o_hit, o_busy, o_data} !== {3'b000, exp_data}) begin
            n_fail++;
            $display("FAIL pulse_hold a=%h got dv=%b hit=%b busy=%b data=%h want 0 0 0 %h",
                     a, o_dv, o_hit, o_busy, o_data, exp_data);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; read_en = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_clear();
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        model_clear();
        n_tests++;
        if ({o_busy, o_dv} !== 2'b00) begin n_fail++; $display("FAIL flush_idle got busy=%b dv=%b want 0 0", o_busy, o_dv); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({o_data, o_dv, o_hit, o_busy, o_mreq, o_maddr} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_state got data=%h dv=%b hit=%b busy=%b req=%b maddr=%h want all 0",
                     o_data, o_dv, o_hit, o_busy, o_mreq, o_maddr);
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_read();
        logic [127:0] line = rand_line();
        line[63:32] = 32'hAAAA_0001;
        do_read(32'h104, line, 0, 1'b0);
        do_read(32'h104, rand_line(), 0, 1'b0);
        n_tests++;
        if (o_data !== 32'hAAAA_0001) begin n_fail++; $display("FAIL cold_reread got %h want aaaa0001", o_data); end
    endtask

    task automatic test_replacement();
        do_reset();
        do_read(32'h0000_0004, rand_line(), 0, 1'b0);
        do_read(32'h1000_0004, rand_line(), 0, 1'b0);
        do_read(32'h2000_0004, rand_line(), 0, 1'b0);
        do_read(32'h1000_0004, rand_line(), 0, 1'b0);
        do_read(32'h0000_0004, rand_line(), 0, 1'b0);
    endtask

    task automatic test_flush();
        do_read(32'h104, rand_line(), 0, 1'b0);
        do_read(32'h208, rand_line(), 0, 1'b0);
        do_read(32'h104, rand_line(), 0, 1'b0);
        do_flush();
        do_read(32'h104, rand_line(), 0, 1'b0);
    endtask

    task automatic test_stall();
        do_read(32'h3000_0048, rand_line(), 10, 1'b1);
        do_read(32'h3000_004C, rand_line(), 0, 1'b0);
    endtask

    task automatic test_reset_in_miss();
        @(negedge clk); addr = 32'h5000_0054; read_en = 1'b1;
        @(negedge clk); read_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_mreq !== 1'b1) begin n_fail++; $display("FAIL rim_req got %b want 1", o_mreq); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_clear();
        n_tests++;
        if ({o_mreq, o_busy, o_dv, o_maddr} !== 35'd0) begin
            n_fail++; $display("FAIL rim_abandon got req=%b busy=%b dv=%b maddr=%h want 0", o_mreq, o_busy, o_dv, o_maddr);
        end
        mem_data_in = rand_line(); mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({o_dv, o_busy, o_mreq} !== 3'b000) begin
                n_fail++; $display("FAIL rim_stray cyc=%0d got dv=%b busy=%b req=%b want 0", i, o_dv, o_busy, o_mreq);
            end
            @(negedge clk);
        end
        do_read(32'h5000_0054, rand_line(), 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 2) << 4) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 9) == 0) do_flush();
            do_read(a, rand_line(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_direct_mapped();
        sel = 1;
        do_reset();
        m_ways = 1;
        for (int n = 0; n < 6; n++) begin
            do_read(n[0] ? 32'h1004 : 32'h0004, rand_line(), 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_replacement();
        test_flush();
        test_stall();
        test_reset_in_miss();
        test_random();
        test_direct_mapped();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
